// File: rtl/cve2_wb_stage.sv
// Writeback stage: registers EX results, waits for and formats load data,
// drives one register-file write port, a retire pulse and a retire counter.
module cve2_wb_stage #(
  parameter bit ResetAll = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  output logic        wb_ready_o,
  input  logic [31:0] ex_result_i,
  input  logic        rf_we_i,
  input  logic [4:0]  rf_waddr_i,
  input  logic        is_load_i,
  input  logic [1:0]  load_size_i,
  input  logic        load_sign_ext_i,
  input  logic [1:0]  load_offset_i,
  input  logic        lsu_rvalid_i,
  input  logic [31:0] lsu_rdata_i,
  input  logic        lsu_err_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        retire_o,
  output logic        load_err_o,
  output logic [31:0] retired_cnt_o
);

  typedef enum logic {
    IDLE,
    WAIT_LOAD
  } state_e;

  state_e      state, state_d;

  logic        accept;
  logic        lsu_done;

  logic        ld_we, ld_we_d;
  logic [4:0]  ld_waddr, ld_waddr_d;
  logic [1:0]  ld_size, ld_size_d;
  logic        ld_sext, ld_sext_d;
  logic [1:0]  ld_off, ld_off_d;

  logic        we_q, we_d;
  logic        retire_q, retire_d;
  logic        err_q, err_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] cnt, cnt_d;
  logic [31:0] ld_data;

  // Ready is held low while reset is asserted, even though state is IDLE.
  assign wb_ready_o = (state == IDLE) & ~rst_i;
  assign accept     = ex_valid_i & wb_ready_o;
  assign lsu_done   = (state == WAIT_LOAD) & lsu_rvalid_i;

  // Select the addressed byte/half/word and extend it to 32 bits.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = lsu_rdata_i[8*ld_off +: 8];
    h = ld_off[1] ? lsu_rdata_i[31:16] : lsu_rdata_i[15:0];
    case (ld_size)
      2'b00:   ld_data = {{24{ld_sext & b[7]}}, b};
      2'b01:   ld_data = {{16{ld_sext & h[15]}}, h};
      default: ld_data = lsu_rdata_i;
    endcase
  end

  // Next-state, load context capture and writeback register values.
  always_comb begin
    state_d    = state;
    ld_we_d    = ld_we;
    ld_waddr_d = ld_waddr;
    ld_size_d  = ld_size;
    ld_sext_d  = ld_sext;
    ld_off_d   = ld_off;
    we_d       = 1'b0;
    retire_d   = 1'b0;
    err_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt;

    unique case (state)
      IDLE: begin
        if (accept && is_load_i) begin
          ld_we_d    = rf_we_i;
          ld_waddr_d = rf_waddr_i;
          ld_size_d  = load_size_i;
          ld_sext_d  = load_sign_ext_i;
          ld_off_d   = load_offset_i;
          state_d    = WAIT_LOAD;
        end else if (accept) begin
          we_d     = rf_we_i & (rf_waddr_i != 5'd0);
          waddr_d  = rf_waddr_i;
          wdata_d  = ex_result_i;
          retire_d = 1'b1;
        end
      end
      WAIT_LOAD: begin
        if (lsu_done) begin
          we_d     = ld_we & (ld_waddr != 5'd0) & ~lsu_err_i;
          err_d    = lsu_err_i;
          waddr_d  = ld_waddr;
          retire_d = 1'b1;
          if (!lsu_err_i) begin
            wdata_d = ld_data;
          end
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (retire_d) begin
      cnt_d = cnt + 32'd1;
    end
  end

  // Control flops: always reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      ld_we    <= 1'b0;
      we_q     <= 1'b0;
      retire_q <= 1'b0;
      err_q    <= 1'b0;
      cnt      <= 32'd0;
    end else begin
      state    <= state_d;
      ld_we    <= ld_we_d;
      we_q     <= we_d;
      retire_q <= retire_d;
      err_q    <= err_d;
      cnt      <= cnt_d;
    end
  end

  generate
    if (ResetAll) begin : g_data_rst
      // Data/address flops with reset.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          ld_waddr <= 5'd0;
          ld_size  <= 2'd0;
          ld_sext  <= 1'b0;
          ld_off   <= 2'd0;
          waddr_q  <= 5'd0;
          wdata_q  <= 32'd0;
        end else begin
          ld_waddr <= ld_waddr_d;
          ld_size  <= ld_size_d;
          ld_sext  <= ld_sext_d;
          ld_off   <= ld_off_d;
          waddr_q  <= waddr_d;
          wdata_q  <= wdata_d;
        end
      end
    end else begin : g_data_nrst
      // Data/address flops without reset.
      always_ff @(posedge clk_i) begin
        ld_waddr <= ld_waddr_d;
        ld_size  <= ld_size_d;
        ld_sext  <= ld_sext_d;
        ld_off   <= ld_off_d;
        waddr_q  <= waddr_d;
        wdata_q  <= wdata_d;
      end
    end
  endgenerate

  assign rf_we_o       = we_q;
  assign rf_waddr_o    = waddr_q;
  assign rf_wdata_o    = wdata_q;
  assign retire_o      = retire_q;
  assign load_err_o    = err_q;
  assign retired_cnt_o = cnt;

endmodule
